imm_narrow_unit: RTL and testbench

//   Inverse of the 16->32 immediate sign extender. Accepts a stream of 32-bit

---
 rtl/imm_narrow_unit.sv | 119 +++++++++++
 tb/tb_imm_narrow_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/imm_narrow_unit.sv
// Narrows 32-bit words to 16-bit immediates through a 2-entry output FIFO.
// Define IMM_SATURATE_EN to saturate out-of-range words instead of truncating.
//
// state | meaning
// EMPTY | no result buffered, out_valid low
// ONE   | one result buffered (head drives out_imm/out_fits)
// TWO   | buffer full, accepts only while draining
module imm_narrow_unit #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_word,
  input  logic             in_unsigned,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_imm,
  output logic             out_fits,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ovf_count
);

  // Encoding equals the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t      state, state_nxt;
  logic        ready_en;
  logic        wr_ptr, rd_ptr, rd_nxt;
  logic [15:0] mem_imm [2];
  logic        mem_fits [2];
  logic        push, pop, fits;
  logic [15:0] imm_new, head_imm;
  logic        head_fits;

  always_comb begin
    if (in_unsigned)
      fits = (in_word[31:16] == 16'h0000);
    else
      fits = (in_word[31:15] == '0) || (in_word[31:15] == '1);
    imm_new = in_word[15:0];
`ifdef IMM_SATURATE_EN
    if (!fits)
      imm_new = in_unsigned ? 16'hFFFF : (in_word[31] ? 16'h8000 : 16'h7FFF);
`endif
  end

  assign out_valid = (state != EMPTY);
  assign pop       = out_valid & out_ready;
  assign in_ready  = ready_en & ((state != TWO) | pop);
  assign push      = in_valid & in_ready;
  assign rd_nxt    = rd_ptr ^ pop;

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = TWO;
        else if (pop && !push) state_nxt = EMPTY;
      end
      TWO:     if (pop && !push) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // The incoming word becomes the head when it lands where the read pointer
  // will point next (empty buffer, or single entry replaced in the same cycle).
  always_comb begin
    if (push && (wr_ptr == rd_nxt)) begin
      head_imm  = imm_new;
      head_fits = fits;
    end else begin
      head_imm  = mem_imm[rd_nxt];
      head_fits = mem_fits[rd_nxt];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= EMPTY;
      ready_en    <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      mem_imm[0]  <= 16'h0000;
      mem_imm[1]  <= 16'h0000;
      mem_fits[0] <= 1'b0;
      mem_fits[1] <= 1'b0;
      out_imm     <= 16'h0000;
      out_fits    <= 1'b0;
      ovf_count   <= '0;
    end else begin
      ready_en <= 1'b1;
      state    <= state_nxt;
      rd_ptr   <= rd_nxt;
      if (push) begin
        mem_imm[wr_ptr]  <= imm_new;
        mem_fits[wr_ptr] <= fits;
        wr_ptr           <= ~wr_ptr;
      end
      if (state_nxt != EMPTY) begin
        out_imm  <= head_imm;
        out_fits <= head_fits;
      end
      if (cnt_clr)
        ovf_count <= '0;
      else if (push && !fits && (ovf_count != CNT_MAX))
        ovf_count <= ovf_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_narrow_unit.sv
// Randomized + directed bench for imm_narrow_unit against a queue-based model.
// Build with IMM_SATURATE_EN defined to check the saturating variant.
module tb_imm_narrow_unit;

  localparam int CNT_W   = 2;
  localparam int OVF_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_word;
  logic             in_unsigned;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_imm;
  logic             out_fits;
  logic             cnt_clr;
  logic [CNT_W-1:0] ovf_count;

  imm_narrow_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word), .in_unsigned(in_unsigned),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fits(out_fits),
    .cnt_clr(cnt_clr), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] imm;
    logic        fits;
  } ent_t;

  ent_t q[$];
  ent_t m_last;
  int   m_ovf;
  bit   rdy_en;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t ref_narrow(input logic [31:0] w, input logic u);
    ent_t e;
    int   sv;
    sv = $signed(w);
    if (u) e.fits = (w <= 32'h0000FFFF);
    else   e.fits = (sv >= -32768) && (sv <= 32767);
    e.imm = w[15:0];
`ifdef IMM_SATURATE_EN
    if (!e.fits) e.imm = u ? 16'hFFFF : ((sv < 0) ? 16'h8000 : 16'h7FFF);
`endif
    return e;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: return r;
      1: return {{16{r[15]}}, r[15:0]};
      2: return {16'h0000, r[15:0]};
      3: return 32'h00008000;
      4: return 32'hFFFF7FFF;
      5: return 32'h00010000;
      6: return 32'hFFFF8000;
      default: return 32'h0000FFFF;
    endcase
  endfunction

  // One clock: check outputs at negedge against the model, advance model at posedge.
  task automatic step(output bit acc);
    bit   ev, er, pu, po;
    ent_t e;
    @(negedge clk);
    ev = (q.size() > 0);
    er = rdy_en && ((q.size() < 2) || (ev && out_ready));
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("ovf_count", 32'(ovf_count), 32'(m_ovf));
    chk("out_imm", 32'(out_imm), 32'(m_last.imm));
    chk("out_fits", 32'(out_fits), 32'(m_last.fits));
    pu = in_valid && er;
    po = ev && out_ready;
    e  = ref_narrow(in_word, in_unsigned);
    @(posedge clk);
    if (po) void'(q.pop_front());
    if (pu) q.push_back(e);
    if (cnt_clr) m_ovf = 0;
    else if (pu && !e.fits && m_ovf < OVF_MAX) m_ovf++;
    rdy_en = 1'b1;
    if (q.size() > 0) m_last = q[0];
    #1;
    acc = pu;
  endtask

  task automatic idle(input int n);
    bit a;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step(a);
  endtask

  task automatic send(input logic [31:0] w, input logic u);
    bit a = 1'b0;
    in_valid = 1'b1; in_word = w; in_unsigned = u;
    for (int i = 0; i < 8 && !a; i++) step(a);
    if (!a) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf  = 0;
    rdy_en = 1'b0;
    m_last = '{16'h0000, 1'b0};
  endtask

  initial begin
    bit a;
    reset_n = 1'b0; in_valid = 1'b0; in_word = '0; in_unsigned = 1'b0;
    out_ready = 1'b0; cnt_clr = 1'b0;
    model_reset();
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_imm", 32'(out_imm), 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    idle(2);

    // sign-extension boundaries, consumer always ready
    out_ready = 1'b1;
    send(32'hFFFF8000, 1'b0);
    chk("t2_imm_a", 32'(out_imm), 32'h8000);
    chk("t2_fits_a", 32'(out_fits), 32'd1);
    send(32'h00007FFF, 1'b0);
    chk("t2_imm_b", 32'(out_imm), 32'h7FFF);
    chk("t2_fits_b", 32'(out_fits), 32'd1);
    chk("t2_ovf", 32'(ovf_count), 32'd0);
    idle(2);

    send(32'h00008000, 1'b0);
    chk("t3_fits_s", 32'(out_fits), 32'd0);
    chk("t3_ovf", 32'(ovf_count), 32'd1);
`ifdef IMM_SATURATE_EN
    chk("t3_imm_s", 32'(out_imm), 32'h7FFF);
`else
    chk("t3_imm_s", 32'(out_imm), 32'h8000);
`endif
    send(32'h00008000, 1'b1);
    chk("t3_fits_u", 32'(out_fits), 32'd1);
    chk("t3_imm_u", 32'(out_imm), 32'h8000);
    idle(2);

    // stalled consumer, three back-to-back words
    out_ready = 1'b0; in_valid = 1'b1; in_unsigned = 1'b0;
    in_word = 32'h00000011; step(a); chk("t4_acc1", 32'(a), 32'd1);
    in_word = 32'h00000022; step(a); chk("t4_acc2", 32'(a), 32'd1);
    in_word = 32'h00000033; step(a); chk("t4_hold1", 32'(a), 32'd0);
    step(a); chk("t4_hold2", 32'(a), 32'd0);
    chk("t4_head", 32'(out_imm), 32'h0011);
    out_ready = 1'b1; step(a); chk("t4_acc3", 32'(a), 32'd1);
    in_valid = 1'b0; step(a);
    chk("t4_second", 32'(out_imm), 32'h0033);
    idle(2);

    // full buffer streaming: accept and consume every cycle
    out_ready = 1'b0;
    send(32'h00000101, 1'b0);
    send(32'h00000202, 1'b0);
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_word = 32'h00001000 + 32'(i);
      step(a);
      chk("t5_acc", 32'(a), 32'd1);
      chk("t5_full", 32'(q.size()), 32'd2);
    end
    idle(4);

    // counter saturation and clear priority
    cnt_clr = 1'b1; idle(1); cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) send(32'h00010000 + 32'(i), 1'b0);
    chk("t6_sat", 32'(ovf_count), 32'(OVF_MAX));
    cnt_clr = 1'b1; send(32'h80000000, 1'b0); cnt_clr = 1'b0;
    chk("t6_clr", 32'(ovf_count), 32'd0);
    send(32'h7FFFFFFF, 1'b0);
    chk("t6_after", 32'(ovf_count), 32'd1);
    idle(2);

    // reset with two entries buffered
    out_ready = 1'b0;
    send(32'h12345678, 1'b0);
    send(32'hFFFFABCD, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("t1_out_valid", 32'(out_valid), 32'd0);
    chk("t1_ovf", 32'(ovf_count), 32'd0);
    chk("t1_in_ready", 32'(in_ready), 32'd0);
    model_reset();
    @(posedge clk); #1 reset_n = 1'b1;
    out_ready = 1'b1;
    step(a);
    chk("t1_ready_after", 32'(in_ready), 32'd1);
    idle(3);

    // randomized traffic
    in_valid = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (!in_valid || a) begin
        in_valid    = ($urandom_range(0, 3) != 0);
        in_word     = rand_word();
        in_unsigned = $urandom_range(0, 1);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      cnt_clr   = ($urandom_range(0, 15) == 0);
      step(a);
    end
    cnt_clr = 1'b0; out_ready = 1'b1;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
